trace_capture: RTL
==================

# trace_capture

Commit-trace buffer downstream of `sccomp_dataflow`. It samples the CPU's `pc`/`inst` outputs on every retired instruction and tags each sample with a cycle stamp. Samples are buffered in a FIFO and streamed to a consumer (trace file writer, UART bridge) over a valid/ready port. Capture stops automatically after a programmed cycle budget, then the buffer drains.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `MAX_CYCLES`, 32'h0000_0230: capture budget in clocks, counted from entering CAPTURE.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  arms capture; sampled in IDLE only.
- `commit`  in  1  an instruction retires this cycle; tied high for the single-cycle core.
- `pc_in`  in  32  PC of retiring instruction.
- `inst_in`  in  32  retiring instruction word.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts head.
- `out_pc`  out  32  head PC.
- `out_inst`  out  32  head instruction.
- `out_cycle`  out  32  head cycle stamp.
- `overflow`  out  1  sticky: ≥1 sample dropped.
- `drop_cnt`  out  16  dropped samples, saturating at 16'hFFFF.
- `done`  out  1  budget reached and FIFO empty.

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: `cycle` = 0; `en`=1 moves to CAPTURE on the next edge.
- CAPTURE: `cycle` increments every clock. A push happens when `commit`=1, with entry {cycle, pc_in, inst_in}. When `cycle` = MAX_CYCLES−1 (the last captured stamp), the state moves to DRAIN on that edge. The push that cycle still occurs.
- DRAIN: no pushes; `cycle` holds. The state moves to DONE on the edge where the FIFO becomes empty. If the FIFO is already empty on entry to DRAIN, it moves to DONE on the next edge.
- DONE: `done`=1; terminal until `rst`. `en` is ignored.
- Pop: `out_valid & out_ready`. The pop is legal in every state.
- Push while full without a same-cycle pop: sample dropped, `overflow` set, `drop_cnt`+1 (saturating).
- Push while full with a same-cycle pop: the push is accepted and the count is unchanged.
- Simultaneous push and pop when non-full: occupancy unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are resolved by a separate occupancy count of log2(DEPTH)+1 bits.
- Outputs `out_pc`/`out_inst`/`out_cycle` are don't-care when `out_valid`=0. The bench must not check them then.

## Timing
- Reset values:
  - state IDLE, `cycle` 0, FIFO empty
  - `out_valid` 0
  - `out_pc`/`out_inst`/`out_cycle` 0
  - `overflow` 0, `drop_cnt` 0, `done` 0
- Latency: a sample pushed at edge N is visible at the head (`out_valid`=1) after edge N, i.e. in the cycle following the push, when the FIFO was empty.
- The head is stable while `out_valid`=1 and `out_ready`=0.
- `rst` asserted mid-capture clears everything immediately, without waiting for a clock. Buffered samples are lost.
- `done` rises in the cycle after the final pop edge.

## Configuration
- `TRACE_FILTER_EN` defined:
  - Adds inputs `filt_lo` and `filt_hi` (32 bits each).
  - A commit is pushed only when filt_lo ≤ pc_in ≤ filt_hi (unsigned compare).
  - Filtered-out commits are not counted as drops.
  - `cycle` still advances every clock.
- `TRACE_FILTER_EN` undefined: the ports are absent and every commit in CAPTURE is pushed.

## Structure
- Package `trace_pkg`:
  - state enum `trace_state_t` {IDLE, CAPTURE, DRAIN, DONE}
  - `trace_entry_t` struct {cycle[31:0], pc[31:0], inst[31:0]}
  - `TRACE_W` = 96
- Sub-module `trace_fifo`: synchronous DEPTH×TRACE_W FIFO with push/pop/full/empty and async-reset pointers.
- The top level holds the FSM, the cycle counter, drop accounting and the optional filter.

## Test plan
- Reset, `en`=1, `commit`=1, `out_ready`=1, pc stepping 0x0040_0000 by 4, MAX_CYCLES=8 → 8 entries, cycle 0..7, pc 0x0040_0000..0x0040_001C; `done`=1 one cycle after the last pop; `overflow`=0.
- `out_ready`=0, DEPTH=16, 20 commits (MAX_CYCLES=20) → 16 entries held, `overflow`=1, `drop_cnt`=4. Releasing ready drains stamps 0..15 in order, then `done`=1.
- FIFO full with `out_ready`=1 and `commit`=1 in the same cycle → push accepted, `drop_cnt` unchanged, order preserved.
- `rst` pulsed asynchronously (mid-clock) during CAPTURE with 5 entries buffered → outputs take their reset values immediately; `out_valid`=0, state IDLE.
- `en`=0 for 10 cycles with `commit`=1 → no entries pushed and `cycle`=0. Then `en`=1 → the first entry has cycle 0.
- `TRACE_FILTER_EN` build, filt_lo=0x0040_0008, filt_hi=0x0040_0010, 8 sequential PCs from 0x0040_0000 → exactly 3 entries (…08, …0C, …10) with stamps 2, 3, 4.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the commit-trace buffer.
//   trace_state_t : capture FSM states (IDLE, CAPTURE, DRAIN, DONE)
//   trace_entry_t : one buffered sample {cycle, pc, inst}
//   TRACE_W       : bit width of one packed trace_entry_t
package trace_pkg;

    localparam int TRACE_W = 96;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [31:0] cycle;
        logic [31:0] pc;
        logic [31:0] inst;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous DEPTH x W first-word-fall-through FIFO.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (pointers/count only)
//   push, din     : write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop           : read request; ignored when empty
//   dout          : head entry, forced to zero while empty
//   full, empty   : occupancy flags
//   level         : current occupancy, 0..DEPTH
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = TRACE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    assign rd_en = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = push & (~full | rd_en);

    // Zero while empty so the head reads as 0 out of reset.
    assign dout = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_capture.sv
// trace_capture: commit-trace buffer. Samples pc/inst of each retired
// instruction with a cycle stamp, buffers them in a FIFO and streams them
// over a valid/ready port. Capture stops after MAX_CYCLES clocks, then the
// buffer drains and done is raised.
// Optional feature macro: TRACE_FILTER_EN adds filt_lo/filt_hi and only
// pushes commits with filt_lo <= pc_in <= filt_hi.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   en                          : arm capture (sampled in IDLE only)
//   commit, pc_in, inst_in      : retiring instruction
//   filt_lo, filt_hi            : PC window (TRACE_FILTER_EN only)
//   out_valid/out_ready         : head handshake
//   out_pc, out_inst, out_cycle : head entry
//   overflow, drop_cnt          : sticky drop flag, saturating drop count
//   done                        : budget reached and FIFO drained
module trace_capture
    import trace_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] MAX_CYCLES = 32'h0000_0230
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        commit,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
`ifdef TRACE_FILTER_EN
    input  logic [31:0] filt_lo,
    input  logic [31:0] filt_hi,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_cycle,
    output logic        overflow,
    output logic [15:0] drop_cnt,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);

    trace_state_t state;
    logic [31:0]  cycle;
    trace_entry_t entry;
    trace_entry_t head;
    logic         in_window;
    logic         push_req;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [AW:0]  fifo_level;
    logic         drop;
    logic         last_stamp;
    logic         empty_next;

`ifdef TRACE_FILTER_EN
    assign in_window = (pc_in >= filt_lo) && (pc_in <= filt_hi);
`else
    assign in_window = 1'b1;
`endif

    assign entry      = '{cycle: cycle, pc: pc_in, inst: inst_in};
    assign push_req   = (state == CAPTURE) & commit & in_window;
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    assign drop       = push_req & fifo_full & ~pop;
    assign last_stamp = (cycle == MAX_CYCLES - 32'd1);
    // In DRAIN nothing is pushed, so the FIFO is empty after this edge if it
    // is empty now or its last entry leaves now.
    assign empty_next = fifo_empty | ((fifo_level == (AW+1)'(1)) & pop);

    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign out_cycle = head.cycle;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (TRACE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch sees the pre-edge values of state, cycle and the FIFO flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cycle    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cycle <= '0;
                    if (en) state <= CAPTURE;
                end
                CAPTURE: begin
                    // The final stamp is still pushed this cycle; the
                    // counter then holds for the rest of the run.
                    if (last_stamp) state <= DRAIN;
                    else            cycle <= cycle + 32'd1;
                end
                DRAIN: begin
                    if (empty_next) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
            endcase

            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule
